// File: rtl/music_pkg.sv
// -----------------------------------------------------------------------------
// music_pkg
// Shared definitions for the music sequencer: sequencer state encoding, the
// two-bit mode encodings, the note frequency table and the elaboration-time
// tone half-period helper.
// -----------------------------------------------------------------------------
package music_pkg;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_PAUSED = 3'd3,
        ST_KEYS   = 3'd4
    } state_e;

    // Values of the mode input.
    localparam logic [1:0] MODE_STOP = 2'b00;
    localparam logic [1:0] MODE_ONCE = 2'b01;
    localparam logic [1:0] MODE_LOOP = 2'b10;
    localparam logic [1:0] MODE_KEYS = 2'b11;

    // Note code -> frequency in Hz. Code 0 is a rest.
    // 1..7 = C4..B4, 8..14 = C5..B5, 15 = C6.
    localparam int NUM_NOTES = 16;
    localparam int NOTE_HZ [NUM_NOTES] = '{
           0,  262,  294,  330,  349,  392,  440,  494,
         523,  587,  659,  698,  784,  880,  988, 1047
    };

    // Tone half-period in clock cycles, floor(clk_hz / (2*f)).
    // Only ever called with constant arguments, so it folds away at
    // elaboration. A rest returns 0.
    function automatic int half_period(input int code, input int clk_hz);
        if (code <= 0 || code >= NUM_NOTES) begin
            return 0;
        end
        return clk_hz / (2 * NOTE_HZ[code]);
    endfunction

endpackage

// File: rtl/music_tone_gen.sv
// -----------------------------------------------------------------------------
// music_tone_gen
// One square-wave voice. A half-period counter runs 0..HALF-1 for the current
// note code and toggles the output phase on each wrap. A change of code
// restarts counter and phase so a new note always begins from a clean low
// phase. Code 0 (rest) holds the output low. While en_i is low the counter
// and phase freeze and the output is forced low.
//
// Ports:
//   clk     in   system clock
//   rst_n   in   synchronous active-low reset
//   code_i  in   note code for this voice
//   en_i    in   1 = run, 0 = freeze and mute
//   spk_o   out  square wave
// -----------------------------------------------------------------------------
module music_tone_gen
    import music_pkg::*;
#(
    parameter int CLK_HZ = 25_000_000,
    parameter int CODE_W = 4,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] code_i,
    input  logic              en_i,
    output logic              spk_o
);

    // Half-period lookup, every entry a constant computed at elaboration.
    logic [DIV_W-1:0] half_tbl [NUM_NOTES];

    for (genvar c = 0; c < NUM_NOTES; c++) begin : g_half
        localparam logic [DIV_W-1:0] HALF = DIV_W'(half_period(c, CLK_HZ));
        assign half_tbl[c] = HALF;
    end

    logic [CODE_W-1:0] code_q;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic              phase_q, phase_d;
    logic [DIV_W-1:0]  half;

    assign half = half_tbl[code_q];

    // NOTE: every signal assigned in always_comb gets a default at the top,
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (code_i != code_q || code_q == '0) begin
            // New note or rest: restart from a clean low phase.
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (en_i) begin
            if (cnt_q == half - DIV_W'(1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_q  <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            code_q  <= code_i;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign spk_o = phase_q & en_i;

endmodule

// File: rtl/music_sequencer.sv
// -----------------------------------------------------------------------------
// music_sequencer
// Multi-voice note player for the 25 MHz board. Note codes come either from an
// external score ROM (play-once or loop over an address window, at a fixed
// tempo, with pause) or directly from the keyboard scanners. Each voice has
// its own square-wave generator; a round-robin mixer samples one voice per
// cycle onto the single buzzer.
//
// Ports:
//   ext_clk_25m  in   system clock
//   ext_rst_n    in   synchronous active-low reset
//   mode         in   00 stop, 01 ROM play-once, 10 ROM loop, 11 keyboard
//   start        in   one-cycle pulse, begin/restart ROM playback
//   pause        in   level, freeze ROM playback
//   start_addr   in   first score address (sampled live)
//   end_addr     in   last score address, inclusive (sampled live)
//   rom_addr     out  score ROM address
//   rom_data     in   score word, one code per voice
//   key_code     in   keyboard codes, one per voice
//   cur_code     out  codes currently sounding
//   busy         out  high in FETCH, PLAY, PAUSED
//   done         out  pulse at end of play-once or on a rejected start
//   spk          out  per-voice square waves
//   spk_mix      out  mixed buzzer output
// -----------------------------------------------------------------------------
module music_sequencer
    import music_pkg::*;
#(
    parameter int CLK_HZ     = 25_000_000,
    parameter int TEMPO_HZ   = 4,
    parameter int NUM_VOICES = 2,
    parameter int ADDR_W     = 10,
    parameter int CODE_W     = 4,
    parameter int DIV_W      = 16
) (
    input  logic                         ext_clk_25m,
    input  logic                         ext_rst_n,
    input  logic [1:0]                   mode,
    input  logic                         start,
    input  logic                         pause,
    input  logic [ADDR_W-1:0]            start_addr,
    input  logic [ADDR_W-1:0]            end_addr,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [NUM_VOICES*CODE_W-1:0] rom_data,
    input  logic [NUM_VOICES*CODE_W-1:0] key_code,
    output logic [NUM_VOICES*CODE_W-1:0] cur_code,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_VOICES-1:0]        spk,
    output logic                         spk_mix
);

    localparam int BUS_W       = NUM_VOICES * CODE_W;
    localparam int BEAT_CYCLES = CLK_HZ / TEMPO_HZ;
    localparam int BEAT_W      = $clog2(BEAT_CYCLES + 1);
    localparam int SEL_W       = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
    localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_VOICES - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [BEAT_W-1:0] beat_q,  beat_d;
    logic [BUS_W-1:0]  cur_q,   cur_d;
    logic              done_q,  done_d;
    logic [SEL_W-1:0]  sel_q,   sel_d;
    logic              mix_q;
    logic              tone_en;

    // ---------------------------------------------------------------------
    // Sequencer next-state logic. Priority: stop, keyboard, then the
    // per-state ROM behaviour (restart, fetch, pause, beat end).
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        cur_d   = cur_q;
        done_d  = 1'b0;

        if (mode == MODE_STOP) begin
            state_d = ST_IDLE;
            cur_d   = '0;
        end else if (mode == MODE_KEYS) begin
            // Loading on the transition edge too keeps key latency at one cycle.
            state_d = ST_KEYS;
            cur_d   = key_code;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (start_addr <= end_addr) begin
                            state_d = ST_FETCH;
                            addr_d  = start_addr;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end

                ST_KEYS: begin
                    state_d = ST_IDLE;
                    cur_d   = '0;
                end

                ST_FETCH, ST_PLAY, ST_PAUSED: begin
                    if (start) begin
                        state_d = ST_FETCH;
                        addr_d  = start_addr;
                    end else if (state_q == ST_FETCH) begin
                        state_d = ST_PLAY;
                        cur_d   = rom_data;
                        beat_d  = '0;
                    end else if (pause) begin
                        // Beat counter holds for every edge pause is seen.
                        state_d = ST_PAUSED;
                    end else begin
                        // The resume edge also counts as a play cycle, so a
                        // pause lengthens the note by exactly its duration.
                        state_d = ST_PLAY;
                        if (beat_q == BEAT_LAST) begin
                            beat_d = '0;
                            if (addr_q != end_addr) begin
                                state_d = ST_FETCH;
                                addr_d  = addr_q + ADDR_W'(1);
                            end else if (mode == MODE_LOOP) begin
                                state_d = ST_FETCH;
                                addr_d  = start_addr;
                            end else begin
                                state_d = ST_IDLE;
                                cur_d   = '0;
                                done_d  = 1'b1;
                            end
                        end else begin
                            beat_d = beat_q + BEAT_W'(1);
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    cur_d   = '0;
                end
            endcase
        end
    end

    // Round-robin mixer slot.
    always_comb begin
        sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
    end

    // NOTE: reset is synchronous and covers every register here; there is no
    // memory array, so nothing is left to power-up state.
    always_ff @(posedge ext_clk_25m) begin
        if (!ext_rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            beat_q  <= '0;
            cur_q   <= '0;
            done_q  <= 1'b0;
            sel_q   <= '0;
            mix_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            cur_q   <= cur_d;
            done_q  <= done_d;
            sel_q   <= sel_d;
            mix_q   <= spk[sel_q];
        end
    end

    // ---------------------------------------------------------------------
    // Voices
    // ---------------------------------------------------------------------
    assign tone_en = (state_q != ST_PAUSED);

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        music_tone_gen #(
            .CLK_HZ (CLK_HZ),
            .CODE_W (CODE_W),
            .DIV_W  (DIV_W)
        ) u_tone (
            .clk    (ext_clk_25m),
            .rst_n  (ext_rst_n),
            .code_i (cur_q[v*CODE_W +: CODE_W]),
            .en_i   (tone_en),
            .spk_o  (spk[v])
        );
    end

    assign rom_addr = addr_q;
    assign cur_code = cur_q;
    assign done     = done_q;
    assign busy     = (state_q == ST_FETCH) || (state_q == ST_PLAY) ||
                      (state_q == ST_PAUSED);
    assign spk_mix  = mix_q;

endmodule

// File: tb/tb_music_sequencer.sv
// -----------------------------------------------------------------------------
// tb_music_sequencer
// Directed bench for music_sequencer at CLK_HZ=25_000, TEMPO_HZ=4
// (6250-cycle beat), two voices. Expected values are hand-computed:
// HALF(code 6, 440 Hz) = 28, HALF(code 1, 262 Hz) = 47, HALF(code 8, 523 Hz) = 23.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_music_sequencer;

    localparam int ADDR_W = 10;
    localparam int BUS_W  = 8;
    localparam int BEAT   = 6250;

    logic              clk;
    logic              rst_n;
    logic [1:0]        mode;
    logic              start;
    logic              pause;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic [ADDR_W-1:0] rom_addr;
    logic [BUS_W-1:0]  rom_data;
    logic [BUS_W-1:0]  key_code;
    logic [BUS_W-1:0]  cur_code;
    logic              busy;
    logic              done;
    logic [1:0]        spk;
    logic              spk_mix;

    logic [BUS_W-1:0]  rom [1024];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Mixer reference: one voice sampled per cycle, alternating from voice 0.
    int   mslot = 0;
    logic mexp  = 1'b0;

    music_sequencer #(
        .CLK_HZ     (25_000),
        .TEMPO_HZ   (4),
        .NUM_VOICES (2),
        .ADDR_W     (ADDR_W),
        .CODE_W     (4),
        .DIV_W      (16)
    ) dut (
        .ext_clk_25m (clk),
        .ext_rst_n   (rst_n),
        .mode        (mode),
        .start       (start),
        .pause       (pause),
        .start_addr  (start_addr),
        .end_addr    (end_addr),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .key_code    (key_code),
        .cur_code    (cur_code),
        .busy        (busy),
        .done        (done),
        .spk         (spk),
        .spk_mix     (spk_mix)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    assign rom_data = rom[rom_addr];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!rst_n) begin
            mslot = 0;
            mexp  = 1'b0;
        end else begin
            mexp  = spk[mslot];
            mslot = (mslot + 1) % 2;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Cycles between two consecutive toggles of spk[v]; -1 on timeout.
    task automatic measure_half(input int v, output int half);
        logic prev;
        int   n;
        half = -1;
        prev = spk[v];
        n = 0;
        while (spk[v] == prev && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) return;
        prev = spk[v];
        n = 0;
        while (spk[v] == prev && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n < 400) half = n;
    endtask

    task automatic pulse_start(input logic [1:0] m, input int sa, input int ea);
        mode       = m;
        start_addr = ADDR_W'(sa);
        end_addr   = ADDR_W'(ea);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    initial begin
        int t0;
        int h;
        int bad;
        int dcnt;
        int icnt;

        for (int i = 0; i < 1024; i++) rom[i] = '0;
        rom[0] = 8'h12;
        rom[1] = 8'h34;
        rom[2] = 8'h5f;
        rom[3] = 8'h06;

        rst_n      = 1'b0;
        mode       = 2'b00;
        start      = 1'b0;
        pause      = 1'b0;
        start_addr = '0;
        end_addr   = '0;
        key_code   = '0;

        // ---------------- reset state ----------------
        step(3);
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_cur_code", 32'(cur_code), 0);
        check("rst_busy",     32'(busy),     0);
        check("rst_done",     32'(done),     0);
        check("rst_spk",      32'(spk),      0);
        check("rst_spk_mix",  32'(spk_mix),  0);
        rst_n = 1'b1;
        step(2);

        // ---------------- 1: single word play-once ----------------
        pulse_start(2'b01, 3, 3);
        check("t1_rom_addr", 32'(rom_addr), 3);
        check("t1_busy",     32'(busy),     1);
        check("t1_cur_early", 32'(cur_code), 0);
        step(1);
        check("t1_cur_code", 32'(cur_code), 32'h06);
        t0 = cyc;
        measure_half(0, h);
        check("t1_half_a", 32'(h), 28);
        check("t1_spk1_rest", 32'(spk[1]), 0);
        measure_half(0, h);
        check("t1_half_b", 32'(h), 28);
        wait_to(t0 + BEAT - 1);
        check("t1_done_early", 32'(done), 0);
        wait_to(t0 + BEAT);
        check("t1_done",     32'(done),     1);
        check("t1_busy_end", 32'(busy),     0);
        check("t1_cur_end",  32'(cur_code), 0);
        step(1);
        check("t1_done_1cyc", 32'(done), 0);
        step(2);
        check("t1_spk_quiet", 32'(spk), 0);

        // ---------------- 4: rejected start ----------------
        pulse_start(2'b01, 5, 2);
        check("t4_done",     32'(done),     1);
        check("t4_busy",     32'(busy),     0);
        check("t4_rom_addr", 32'(rom_addr), 3);
        step(1);
        check("t4_done_1cyc", 32'(done), 0);
        check("t4_busy_after", 32'(busy), 0);

        // ---------------- 2: loop over 0..2 ----------------
        pulse_start(2'b10, 0, 2);
        t0 = cyc;
        check("t2_addr0", 32'(rom_addr), 0);
        dcnt = 0;
        icnt = 0;
        step(1);
        check("t2_cur0", 32'(cur_code), 32'h12);
        for (int k = 1; k <= 4; k++) begin
            while (cyc < t0 + k * 6251) begin
                if (done) dcnt++;
                if (!busy) icnt++;
                @(negedge clk);
            end
            check($sformatf("t2_addr_step%0d", k), 32'(rom_addr), 32'(k % 3));
        end
        check("t2_done_never", 32'(dcnt), 0);
        check("t2_busy_held",  32'(icnt), 0);
        mode = 2'b00;
        step(1);
        check("t2_stop_busy", 32'(busy),     0);
        check("t2_stop_cur",  32'(cur_code), 0);
        check("t2_stop_done", 32'(done),     0);

        // ---------------- 3: pause for 1000 cycles ----------------
        pulse_start(2'b01, 3, 3);
        step(1);
        t0 = cyc;
        check("t3_cur", 32'(cur_code), 32'h06);
        wait_to(t0 + 2000);
        pause = 1'b1;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (spk !== 2'b00) bad++;
            if (busy !== 1'b1) bad++;
        end
        pause = 1'b0;
        check("t3_spk_muted", 32'(bad), 0);
        wait_to(t0 + BEAT);
        check("t3_not_done_unpaused_time", 32'(done), 0);
        wait_to(t0 + BEAT + 999);
        check("t3_done_early", 32'(done), 0);
        wait_to(t0 + BEAT + 1000);
        check("t3_done", 32'(done), 1);
        step(1);

        // ---------------- 5: keyboard ----------------
        key_code = 8'h81;
        mode     = 2'b11;
        step(1);
        check("t5_cur",  32'(cur_code), 32'h81);
        check("t5_busy", 32'(busy),     0);
        measure_half(0, h);
        check("t5_half_v0", 32'(h), 47);
        measure_half(1, h);
        check("t5_half_v1", 32'(h), 23);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (spk_mix !== mexp) bad++;
        end
        check("t5_mix", 32'(bad), 0);
        key_code = 8'h00;
        step(1);
        check("t5_cur_rest", 32'(cur_code), 0);
        step(2);
        check("t5_spk_rest", 32'(spk), 0);
        mode = 2'b00;
        step(1);
        check("t5_exit_cur", 32'(cur_code), 0);

        // ---------------- 6: reset during PLAY ----------------
        pulse_start(2'b01, 0, 2);
        step(100);
        check("t6_playing", 32'(busy), 1);
        rst_n = 1'b0;
        step(1);
        check("t6_rom_addr", 32'(rom_addr), 0);
        check("t6_cur",      32'(cur_code), 0);
        check("t6_busy",     32'(busy),     0);
        check("t6_done",     32'(done),     0);
        check("t6_spk",      32'(spk),      0);
        check("t6_spk_mix",  32'(spk_mix),  0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done !== 1'b0) bad++;
            if (busy !== 1'b0) bad++;
        end
        check("t6_idle_after", 32'(bad), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/music_sequencer.md
Name: music_sequencer

Overview:
- Parametrised successor to the single-voice ROM/keyboard player, for the 25 MHz board.
- Plays NUM_VOICES simultaneous note codes. Codes come either from an external score ROM, with selectable address window, tempo, play-once/loop modes and pause, or directly from keyboard scanners.
- Each voice drives its own square-wave tone generator. A round-robin mixer drives the single buzzer.
- Sits between the ROM/keyboard front ends and the speaker and display logic.

Parameters:
- CLK_HZ, 25_000_000, system clock frequency; sets tone half-periods and beat length.
- TEMPO_HZ, 4, note beats per second; BEAT_CYCLES = CLK_HZ/TEMPO_HZ.
- NUM_VOICES, 2, number of parallel voices (1..4).
- ADDR_W, 10, score ROM address width.
- CODE_W, 4, note code width per voice (fixed 4; table has 16 entries).
- DIV_W, 16, tone half-period counter width.

Ports:
- ext_clk_25m  in  1  system clock.
- ext_rst_n  in  1  reset, synchronous, active-low.
- mode  in  2  00 stop, 01 ROM play-once, 10 ROM loop, 11 keyboard.
- start  in  1  one-cycle pulse; begin ROM playback.
- pause  in  1  level; freeze ROM playback.
- start_addr  in  ADDR_W  first score address.
- end_addr  in  ADDR_W  last score address, inclusive.
- rom_addr  out  ADDR_W  score ROM address.
- rom_data  in  NUM_VOICES*CODE_W  score word; valid one cycle after rom_addr.
- key_code  in  NUM_VOICES*CODE_W  keyboard codes, already synchronised.
- cur_code  out  NUM_VOICES*CODE_W  codes currently sounding; for the display.
- busy  out  1  high in FETCH, PLAY, PAUSED.
- done  out  1  one-cycle pulse at end of play-once, or on a rejected start.
- spk  out  NUM_VOICES  per-voice square wave.
- spk_mix  out  1  mixed buzzer output.

Behaviour:
- Reset values: all outputs 0; state IDLE; rom_addr 0; tone phases 0.
- Note table: code 0 is a rest. Codes 1-7 are C4..B4 (262,294,330,349,392,440,494 Hz). Codes 8-14 are C5..B5 (523,587,659,698,784,880,988 Hz). Code 15 is C6 (1047 Hz).
- Half-period: HALF[c] = CLK_HZ/(2*f), integer floor, computed at elaboration.
- States: IDLE, FETCH, PLAY, PAUSED, KEYS.
- IDLE:
  - mode=11 -> KEYS.
  - start with mode 01/10 and start_addr <= end_addr -> FETCH, rom_addr = start_addr.
  - start with start_addr > end_addr -> done pulse, stay IDLE.
  - start with mode 00 is ignored.
- FETCH (1 cycle) -> PLAY. On entry to PLAY: cur_code <= rom_data, beat counter <= 0.
- Start latency: start sampled in cycle N; rom_addr valid N+1; cur_code updated N+2.
- PLAY: beat counter increments each cycle. At BEAT_CYCLES-1:
  - rom_addr != end_addr -> rom_addr+1, FETCH.
  - rom_addr == end_addr, mode 10 -> rom_addr = start_addr, FETCH.
  - rom_addr == end_addr, mode 01 -> done pulse, cur_code <= 0, IDLE.
- PLAY with pause=1 -> PAUSED. Beat counter and tone counters hold; spk forced 0.
- PAUSED with pause=0 -> PLAY, resuming the remaining beat count.
- start while busy: restarts from start_addr (FETCH), no done pulse.
- mode=00 in any state: next cycle IDLE, cur_code <= 0; no done pulse.
- mode=11 from a ROM state: abandon playback, go to KEYS.
- KEYS: cur_code <= key_code every cycle (1-cycle latency). mode != 11 -> IDLE, cur_code <= 0.
- Voice i uses bits [i*CODE_W +: CODE_W] of each code bus.
- Tone generator, per voice:
  - Counter 0..HALF-1; toggles spk[i] on wrap.
  - Any change of the voice's code resets counter and phase to 0, so there is no glitch carry-over.
  - Code 0 holds spk[i] = 0.
- Mixer: a mod-NUM_VOICES counter advances every cycle. spk_mix = spk[sel] of the current slot, registered (1-cycle delay). With NUM_VOICES=1, spk_mix = spk[0] delayed one cycle.
- Address arithmetic is ADDR_W bits. start_addr = end_addr plays a single word.
- start_addr/end_addr are sampled live: the loop reload and end compare use current port values.
- Reset mid-operation: next edge returns every register to its reset value regardless of state.

Decomposition:
- Package music_pkg:
  - state enum.
  - Mode encodings.
  - Note frequency constant array.
  - Function half_period(code, CLK_HZ).
- One sub-module, music_tone_gen: one voice; inputs code, enable; output square wave. Instantiated NUM_VOICES times by generate.
- Sequencer FSM and mixer stay in music_sequencer.

Test Plan:
Benches use CLK_HZ=25_000, TEMPO_HZ=4 (BEAT_CYCLES=6250) and NUM_VOICES=2.
1. ROM holds {voice1=0, voice0=6} at address 3; mode=01, start_addr=end_addr=3, start pulse -> rom_addr=3 next cycle; cur_code=0x06 two cycles after start; spk[0] period 56 cycles (HALF=28); spk[1]=0; done pulse 6250 cycles after cur_code update; then IDLE.
2. mode=10, addresses 0..2 -> addresses cycle 0,1,2,0,1 at 6251-cycle intervals; done never asserts; busy stays 1.
3. Pause held 1000 cycles mid-note -> spk=0 throughout; after release the note ends 1000 cycles later than unpaused.
4. start_addr=5, end_addr=2, start -> single done pulse, busy stays 0, rom_addr unchanged.
5. mode=11, key_code=0x81 -> cur_code=0x81 after 1 cycle; spk[0] half-period 47; spk[1] half-period 23; spk_mix alternates slots; change key to 0x00 -> both spk 0.
6. ext_rst_n=0 for one edge during PLAY -> all outputs 0 and state IDLE on that edge; no done pulse.
